// File: rtl/e203_dtcm_ram_arb.sv
// Two-port round-robin DTCM SRAM arbiter with optional light-sleep FSM (E203_DTCM_ARB_LS_EN).
// Latency: grant drives ram_cs combinationally; response one cycle after grant (two extra on wake).
// Backpressure: an unaccepted response holds its data and blocks new grants on both ports.
module e203_dtcm_ram_arb #(
   parameter int AW       = 14,
   parameter int DW       = 32,
   parameter int IDLE_CYC = 16
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            lsu_cmd_valid,
   output logic            lsu_cmd_ready,
   input  logic            lsu_cmd_read,
   input  logic [AW-1:0]   lsu_cmd_addr,
   input  logic [DW-1:0]   lsu_cmd_wdata,
   input  logic [DW/8-1:0] lsu_cmd_wmask,
   output logic            lsu_rsp_valid,
   input  logic            lsu_rsp_ready,
   output logic [DW-1:0]   lsu_rsp_rdata,

   input  logic            ext_cmd_valid,
   output logic            ext_cmd_ready,
   input  logic            ext_cmd_read,
   input  logic [AW-1:0]   ext_cmd_addr,
   input  logic [DW-1:0]   ext_cmd_wdata,
   input  logic [DW/8-1:0] ext_cmd_wmask,
   output logic            ext_rsp_valid,
   input  logic            ext_rsp_ready,
   output logic [DW-1:0]   ext_rsp_rdata,

   output logic            ram_cs,
   output logic            ram_we,
   output logic [AW-1:0]   ram_addr,
   output logic [DW/8-1:0] ram_wem,
   output logic [DW-1:0]   ram_din,
   input  logic [DW-1:0]   ram_dout,
   output logic            ram_sd,
   output logic            ram_ds,
   output logic            ram_ls
);

   if (IDLE_CYC < 1 || IDLE_CYC > 255) begin : g_bad_idle_cyc
      $error("IDLE_CYC must be within 1..255");
   end

   logic          rst_q;
   logic          last_lsu;
   logic          rsp_pend;
   logic          rsp_own;
   logic          rsp_first;
   logic          rsp_rd;
   logic [DW-1:0] hold_q;

   logic          run;
   logic          rsp_acc;
   logic          allow;
   logic          lsu_pick;
   logic          ext_pick;
   logic          lsu_gnt;
   logic          ext_gnt;
   logic          gnt;
   logic          sel_read;
   logic          rsp_vld;
   logic [DW-1:0] rsp_dat;

   // lsu wins ties unless it was the most recent winner
   assign lsu_pick = lsu_cmd_valid && (!ext_cmd_valid || !last_lsu);
   assign ext_pick = ext_cmd_valid && !lsu_pick;

   assign rsp_acc = rsp_pend && (rsp_own ? ext_rsp_ready : lsu_rsp_ready);
   assign allow   = run && !rst && !rst_q && (!rsp_pend || rsp_acc);

   assign lsu_cmd_ready = allow && lsu_pick;
   assign ext_cmd_ready = allow && ext_pick;
   assign lsu_gnt       = lsu_cmd_valid && lsu_cmd_ready;
   assign ext_gnt       = ext_cmd_valid && ext_cmd_ready;
   assign gnt           = lsu_gnt || ext_gnt;

   assign sel_read = ext_pick ? ext_cmd_read : lsu_cmd_read;
   assign ram_cs   = gnt;
   assign ram_we   = !sel_read;
   assign ram_addr = ext_pick ? ext_cmd_addr  : lsu_cmd_addr;
   assign ram_din  = ext_pick ? ext_cmd_wdata : lsu_cmd_wdata;
   assign ram_wem  = sel_read ? {(DW/8){1'b1}} : (ext_pick ? ext_cmd_wmask : lsu_cmd_wmask);
   assign ram_sd   = 1'b0;
   assign ram_ds   = 1'b0;

   // SRAM data is only valid in the first response cycle; afterwards the hold register serves it
   assign rsp_vld       = rsp_pend && !rst;
   assign rsp_dat       = (rsp_first && rsp_rd) ? ram_dout : hold_q;
   assign lsu_rsp_valid = rsp_vld && !rsp_own;
   assign ext_rsp_valid = rsp_vld && rsp_own;
   assign lsu_rsp_rdata = rsp_dat;
   assign ext_rsp_rdata = rsp_dat;

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_q     <= 1'b1;
         last_lsu  <= 1'b0;
         rsp_pend  <= 1'b0;
         rsp_own   <= 1'b0;
         rsp_first <= 1'b0;
         rsp_rd    <= 1'b0;
         hold_q    <= '0;
      end else begin
         rst_q <= 1'b0;
         if (gnt) begin
            last_lsu  <= lsu_gnt;
            rsp_pend  <= 1'b1;
            rsp_own   <= ext_gnt;
            rsp_first <= 1'b1;
            rsp_rd    <= sel_read;
         end else begin
            rsp_first <= 1'b0;
            if (rsp_acc)
               rsp_pend <= 1'b0;
         end
         if (gnt && !sel_read)
            hold_q <= '0;
         else if (rsp_first && rsp_rd)
            hold_q <= ram_dout;
      end
   end

`ifdef E203_DTCM_ARB_LS_EN
   typedef enum logic [1:0] {RUN, SLEEP, WAKE} state_t;

   localparam logic [7:0] IDLE_LIM = 8'(IDLE_CYC);

   state_t     state_q;
   state_t     state_d;
   logic [7:0] idle_cnt;
   logic [7:0] idle_cnt_d;

   assign run    = (state_q == RUN);
   assign ram_ls = !rst && (state_q != RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RUN;
         idle_cnt <= '0;
      end else begin
         state_q  <= state_d;
         idle_cnt <= idle_cnt_d;
      end
   end

   // a grant in the cycle the limit is hit keeps the arbiter awake
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt;
      case (state_q)
         RUN: begin
            if (gnt || rsp_pend) begin
               idle_cnt_d = '0;
            end else if (idle_cnt == IDLE_LIM) begin
               state_d    = SLEEP;
               idle_cnt_d = '0;
            end else if (idle_cnt != 8'hFF) begin
               idle_cnt_d = idle_cnt + 8'd1;
            end
         end
         SLEEP: begin
            idle_cnt_d = '0;
            if (lsu_cmd_valid || ext_cmd_valid)
               state_d = WAKE;
         end
         WAKE: begin
            idle_cnt_d = '0;
            state_d    = RUN;
         end
         default: begin
            idle_cnt_d = '0;
            state_d    = RUN;
         end
      endcase
   end
`else
   assign run    = 1'b1;
   assign ram_ls = 1'b0;
`endif

endmodule

// File: tb/tb_e203_dtcm_ram_arb.sv
// Scoreboarded bench for e203_dtcm_ram_arb: directed commands push expected rdata, a monitor pops on accept.
module tb_e203_dtcm_ram_arb;
   localparam int AW = 14;
   localparam int DW = 32;
   localparam int MW = 4;

   typedef struct {
      logic          rd;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [MW-1:0] m;
      logic [DW-1:0] exp;
   } cmd_t;

   logic clk = 1'b0;
   logic rst;
   logic lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read;
   logic [AW-1:0] lsu_cmd_addr;
   logic [DW-1:0] lsu_cmd_wdata;
   logic [MW-1:0] lsu_cmd_wmask;
   logic lsu_rsp_valid, lsu_rsp_ready;
   logic [DW-1:0] lsu_rsp_rdata;
   logic ext_cmd_valid, ext_cmd_ready, ext_cmd_read;
   logic [AW-1:0] ext_cmd_addr;
   logic [DW-1:0] ext_cmd_wdata;
   logic [MW-1:0] ext_cmd_wmask;
   logic ext_rsp_valid, ext_rsp_ready;
   logic [DW-1:0] ext_rsp_rdata;
   logic ram_cs, ram_we, ram_sd, ram_ds, ram_ls;
   logic [AW-1:0] ram_addr;
   logic [MW-1:0] ram_wem;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [DW-1:0] q_lsu[$];
   logic [DW-1:0] q_ext[$];
   logic [DW-1:0] mem [0:(1<<AW)-1];

   e203_dtcm_ram_arb #(.AW(AW), .DW(DW), .IDLE_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
      .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
      .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(ext_cmd_ready), .ext_cmd_read(ext_cmd_read),
      .ext_cmd_addr(ext_cmd_addr), .ext_cmd_wdata(ext_cmd_wdata), .ext_cmd_wmask(ext_cmd_wmask),
      .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready), .ext_rsp_rdata(ext_rsp_rdata),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem), .ram_din(ram_din),
      .ram_dout(ram_dout), .ram_sd(ram_sd), .ram_ds(ram_ds), .ram_ls(ram_ls)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: output is garbage on cycles without a read, so only a true hold register keeps rdata stable
   initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
   always @(posedge clk) begin
      if (ram_cs && !ram_we) begin
         ram_dout <= mem[ram_addr];
      end else begin
         ram_dout <= $urandom;
         if (ram_cs)
            for (int b = 0; b < MW; b++)
               if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event did not occur within cycle budget", name);
   endtask

   // monitor: pops one expectation per accepted response
   always @(negedge clk) begin
      if (lsu_rsp_valid && lsu_rsp_ready) begin
         if (q_lsu.size() == 0) bound_fail("lsu_rsp_unexpected");
         else check("lsu_rsp_rdata", lsu_rsp_rdata, q_lsu.pop_front());
      end
      if (ext_rsp_valid && ext_rsp_ready) begin
         if (q_ext.size() == 0) bound_fail("ext_rsp_unexpected");
         else check("ext_rsp_rdata", ext_rsp_rdata, q_ext.pop_front());
      end
      if (lsu_rsp_valid || ext_rsp_valid)
         check("rsp_exclusive", lsu_rsp_valid && ext_rsp_valid, 0);
   end

   task automatic drv(input bit p, input bit v, input cmd_t c);
      if (!p) begin
         lsu_cmd_valid = v; lsu_cmd_read = c.rd; lsu_cmd_addr = c.a;
         lsu_cmd_wdata = c.d; lsu_cmd_wmask = c.m;
      end else begin
         ext_cmd_valid = v; ext_cmd_read = c.rd; ext_cmd_addr = c.a;
         ext_cmd_wdata = c.d; ext_cmd_wmask = c.m;
      end
   endtask

   // single command on one port; returns #1 after the grant edge
   task automatic issue(input bit p, input cmd_t c, output int gcyc);
      gcyc = -1;
      drv(p, 1'b1, c);
      for (int i = 0; i < 50 && gcyc < 0; i++) begin
         @(negedge clk);
         if (p ? ext_cmd_ready : lsu_cmd_ready) begin
            gcyc = cyc;
            if (p) q_ext.push_back(c.exp); else q_lsu.push_back(c.exp);
         end
      end
      if (gcyc < 0) bound_fail("issue_timeout");
      @(posedge clk); #1;
      drv(p, 1'b0, c);
   endtask

   // both ports streaming; grants must alternate starting with lsu
   task automatic dual(input cmd_t lq[$], input cmd_t eq[$], input string tag);
      int li = 0, ei = 0, k = 0, guard = 0;
      drv(1'b0, lq.size() > 0, lq[0]);
      drv(1'b1, eq.size() > 0, eq[0]);
      while ((li < lq.size() || ei < eq.size()) && guard < 40) begin
         @(negedge clk);
         guard++;
         if (lsu_cmd_valid && lsu_cmd_ready) begin
            check($sformatf("%s_grant%0d_port", tag, k), 0, k % 2);
            q_lsu.push_back(lq[li].exp);
            li++; k++;
         end
         if (ext_cmd_valid && ext_cmd_ready) begin
            check($sformatf("%s_grant%0d_port", tag, k), 1, k % 2);
            q_ext.push_back(eq[ei].exp);
            ei++; k++;
         end
         @(posedge clk); #1;
         drv(1'b0, li < lq.size(), lq[(li < lq.size()) ? li : 0]);
         drv(1'b1, ei < eq.size(), eq[(ei < eq.size()) ? ei : 0]);
      end
      if (guard >= 40) bound_fail({tag, "_timeout"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_t lq[$];
      cmd_t eq[$];
      cmd_t c;
      int g1, g2, n;

      rst = 1'b1;
      lsu_rsp_ready = 1'b1;
      ext_rsp_ready = 1'b1;
      c = '{1'b1, '0, '0, '0, '0};
      drv(1'b0, 1'b1, c);
      drv(1'b1, 1'b1, c);

      // reset and post-reset hold cycle with both requesters asserting valid
      @(negedge clk);
      check("rst_ram_cs", ram_cs, 0);
      check("rst_cmd_ready", {lsu_cmd_ready, ext_cmd_ready}, 0);
      check("rst_rsp_valid", {lsu_rsp_valid, ext_rsp_valid}, 0);
      check("rst_ram_ls", ram_ls, 0);
      check("ram_sd_ds", {ram_sd, ram_ds}, 0);
      @(posedge clk); #1 rst = 1'b0;
      drv(1'b0, 1'b0, c);
      drv(1'b1, 1'b0, c);
      @(negedge clk);
      check("hold_ram_cs", ram_cs, 0);
      check("hold_cmd_ready", {lsu_cmd_ready, ext_cmd_ready}, 0);
      @(posedge clk); #1;

      // contention: four writes alternate lsu, ext, lsu, ext
      lq = {};
      eq = {};
      lq.push_back('{1'b0, 14'h20, 32'h1111_1111, 4'hF, 32'h0});
      lq.push_back('{1'b0, 14'h21, 32'h3333_3333, 4'hF, 32'h0});
      eq.push_back('{1'b0, 14'h30, 32'h2222_2222, 4'hF, 32'h0});
      eq.push_back('{1'b0, 14'h31, 32'h4444_4444, 4'hF, 32'h0});
      dual(lq, eq, "contend");
      repeat (2) @(posedge clk);
      #1;

      // back-to-back write then read on lsu
      issue(1'b0, '{1'b0, 14'h10, 32'hA5A5_A5A5, 4'hF, 32'h0}, g1);
      issue(1'b0, '{1'b1, 14'h10, 32'h0, 4'h0, 32'hA5A5_A5A5}, g2);
      check("b2b_consecutive", g2, g1 + 1);
      @(negedge clk);
      check("rd_rsp_valid_next", lsu_rsp_valid, 1);
      check("rd_rsp_rdata_next", lsu_rsp_rdata, 32'hA5A5_A5A5);
      @(posedge clk); #1;

      // partial byte mask and cross-port readback
      issue(1'b0, '{1'b0, 14'h20, 32'hDEAD_BEEF, 4'h3, 32'h0}, g1);
      issue(1'b1, '{1'b1, 14'h20, 32'h0, 4'h0, 32'h1111_BEEF}, g1);
      issue(1'b1, '{1'b1, 14'h31, 32'h0, 4'h0, 32'h4444_4444}, g1);
      repeat (2) @(posedge clk);
      #1;

      // backpressure: lsu read stalled 3 cycles while ext waits
      lsu_rsp_ready = 1'b0;
      issue(1'b0, '{1'b1, 14'h10, 32'h0, 4'h0, 32'hA5A5_A5A5}, g1);
      drv(1'b1, 1'b1, '{1'b1, 14'h21, 32'h0, 4'h0, 32'h0});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("bp_valid_%0d", i), lsu_rsp_valid, 1);
         check($sformatf("bp_rdata_%0d", i), lsu_rsp_rdata, 32'hA5A5_A5A5);
         check($sformatf("bp_no_grant_%0d", i), ram_cs, 0);
         @(posedge clk); #1;
      end
      lsu_rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_valid_accept", lsu_rsp_valid, 1);
      check("bp_grant_on_accept", ext_cmd_ready, 1);
      if (ext_cmd_ready) q_ext.push_back(32'h3333_3333);
      @(posedge clk); #1;
      ext_cmd_valid = 1'b0;
      @(negedge clk);
      check("bp_valid_dropped", lsu_rsp_valid, 0);
      check("bp_ext_rsp", ext_rsp_valid, 1);
      @(posedge clk); #1;

      // reset the cycle after an lsu read grant
      issue(1'b0, '{1'b1, 14'h10, 32'h0, 4'h0, 32'hA5A5_A5A5}, g1);
      rst = 1'b1;
      q_lsu.delete();
      @(negedge clk);
      check("rst_mid_rsp_valid", lsu_rsp_valid, 0);
      @(posedge clk); #1 rst = 1'b0;
      lq = {};
      eq = {};
      lq.push_back('{1'b1, 14'h31, 32'h0, 4'h0, 32'h4444_4444});
      eq.push_back('{1'b1, 14'h10, 32'h0, 4'h0, 32'hA5A5_A5A5});
      dual(lq, eq, "post_rst");
      repeat (3) @(posedge clk);
      #1;

`ifdef E203_DTCM_ARB_LS_EN
      // light-sleep entry after idle, two-cycle wake on ext request
      n = 0;
      while (!ram_ls && n < 40) begin
         @(negedge clk);
         if (!ram_ls) n++;
      end
      check("ls_entry_window", (n >= 15 && n <= 20), 1);
      @(posedge clk); #1;
      drv(1'b1, 1'b1, '{1'b1, 14'h31, 32'h0, 4'h0, 32'h0});
      @(negedge clk);
      check("ls_sleep_ls", ram_ls, 1);
      check("ls_sleep_ready", ext_cmd_ready, 0);
      @(negedge clk);
      check("ls_wake_ls", ram_ls, 1);
      check("ls_wake_ready", ext_cmd_ready, 0);
      @(negedge clk);
      check("ls_run_ls", ram_ls, 0);
      check("ls_run_grant", ext_cmd_ready, 1);
      if (ext_cmd_ready) q_ext.push_back(32'h4444_4444);
      @(posedge clk); #1;
      ext_cmd_valid = 1'b0;
`endif

      repeat (4) @(posedge clk);
      @(negedge clk);
      check("lsu_q_drained", q_lsu.size(), 0);
      check("ext_q_drained", q_ext.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
